// File: rtl/image_bram_reader.sv
`default_nettype none
// ============================================================================
// Module      : image_bram_reader
// Description : Scans one image out of a negedge-clocked BRAM (addresses
//               0..NUM_PIXELS-1) and presents the pixels as a valid/ready
//               stream tagged with index and last flag. A 2-entry buffer with
//               credit-based read issue absorbs consumer backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module image_bram_reader #(
    parameter int NUM_PIXELS = 169,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic              BRAM_EN,
    output logic              BRAM_WE,
    output logic [DATA_W-1:0] BRAM_DI,
    input  logic [DATA_W-1:0] BRAM_DO,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic [ADDR_W-1:0] PIX_INDEX,
    output logic              PIX_LAST,
    output logic              PIX_VALID,
    input  logic              PIX_READY
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] issue_cnt;
    logic              issue;
    logic              push;
    logic              pop;
    logic              credit_ok;
    logic [2:0]        occupancy;

    logic [DATA_W-1:0] fifo_data  [2];
    logic [ADDR_W-1:0] fifo_index [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;

    // A read issued on the previous edge has its data on BRAM_DO now,
    // because the BRAM sampled the registered address on the falling edge.
    assign push = BRAM_EN;
    assign pop  = PIX_VALID & PIX_READY;

    // Pixels buffered plus in flight, after this edge's pop; a new read is
    // only allowed while this stays below the buffer depth.
    assign occupancy = {1'b0, fifo_count} + {2'b00, BRAM_EN} - {2'b00, pop};
    assign credit_ok = (occupancy < 3'd2);

    assign BUSY    = (state == S_READ) || (state == S_DRAIN);
    assign DONE    = (state == S_FINISH);
    assign BRAM_WE = 1'b0;
    assign BRAM_DI = '0;

    // Output stream is the buffer head, forced to zero while empty.
    assign PIX_VALID = (fifo_count != 2'd0);
    assign PIX_DATA  = PIX_VALID ? fifo_data[rd_ptr]  : '0;
    assign PIX_INDEX = PIX_VALID ? fifo_index[rd_ptr] : '0;
    assign PIX_LAST  = PIX_VALID && (fifo_index[rd_ptr] == LAST_ADDR);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and read-issue decision.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                // Buffer is empty in IDLE, so the first read always has credit.
                if (START) begin
                    issue      = 1'b1;
                    state_next = (issue_cnt == LAST_ADDR) ? S_DRAIN : S_READ;
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_cnt == LAST_ADDR) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && PIX_LAST) begin
                    state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // BRAM read port and issue counter; address holds when no read issues.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BRAM_EN   <= 1'b0;
            BRAM_ADDR <= '0;
            issue_cnt <= '0;
        end else begin
            BRAM_EN <= issue;
            if (issue) begin
                BRAM_ADDR <= issue_cnt;
                if (issue_cnt != LAST_ADDR) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
            end
            if (state == S_FINISH) begin
                issue_cnt <= '0;
            end
        end
    end

    // Two-entry output buffer; simultaneous push and pop are both honoured.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_index[0] <= '0;
            fifo_index[1] <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_count    <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr]  <= BRAM_DO;
                fifo_index[wr_ptr] <= BRAM_ADDR;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
`default_nettype wire
